// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, two write ports and clear control.
interface regfile_mp_if #(
  parameter int unsigned n  = 16,
  parameter int unsigned r  = 4,
  parameter int unsigned NR = 3
);
  logic [NR*r-1:0] ra;
  logic [NR*n-1:0] rd;
  logic            we0;
  logic            we1;
  logic [r-1:0]    wa0;
  logic [r-1:0]    wa1;
  logic [n-1:0]    wd0;
  logic [n-1:0]    wd1;
  logic            clr_req;
  logic            busy;
  logic            clr_done;

  modport master (
    output ra, we0, we1, wa0, wa1, wd0, wd1, clr_req,
    input  rd, busy, clr_done
  );

  modport slave (
    input  ra, we0, we1, wa0, wa1, wd0, wd1, clr_req,
    output rd, busy, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NR combinational reads, two synchronous writes, optional
// write-first bypass and a sequential clear engine that zeroes registers 1..2**r-1.
module regfile_mp #(
  parameter int unsigned n      = 16,
  parameter int unsigned r      = 4,
  parameter int unsigned NR     = 3,
  parameter int unsigned BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);
  localparam int unsigned Depth = 2 ** r;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e         state_q;
  logic [r-1:0]   ptr_q;
  logic           busy_q;
  logic           clr_done_q;
  logic [n-1:0]   rf_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= r'(1);
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      for (int i = 0; i < Depth; i++) rf_q[i] <= '0;
    end else begin
      clr_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Port 1 is assigned last so it wins an address collision.
          if (bus.we0 && bus.wa0 != '0) rf_q[bus.wa0] <= bus.wd0;
          if (bus.we1 && bus.wa1 != '0) rf_q[bus.wa1] <= bus.wd1;
          if (bus.clr_req) begin
            state_q <= StClear;
            busy_q  <= 1'b1;
            ptr_q   <= r'(1);
          end
        end
        StClear: begin
          rf_q[ptr_q] <= '0;
          ptr_q       <= ptr_q + r'(1);
          if (ptr_q == '1) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b1;
            ptr_q      <= r'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [NR*n-1:0] rd_c;
  logic [r-1:0]    addr;

  always_comb begin
    rd_c = '0;
    addr = '0;
    for (int k = 0; k < NR; k++) begin
      addr = bus.ra[k*r +: r];
      rd_c[k*n +: n] = rf_q[addr];
      // Bypass is suppressed while clearing because writes are masked then.
      if (BYPASS != 0 && !busy_q && addr != '0) begin
        if (bus.we1 && bus.wa1 == addr) begin
          rd_c[k*n +: n] = bus.wd1;
        end else if (bus.we0 && bus.wa0 == addr) begin
          rd_c[k*n +: n] = bus.wd0;
        end
      end
      if (addr == '0) rd_c[k*n +: n] = '0;
    end
  end

  assign bus.rd       = rd_c;
  assign bus.busy     = busy_q;
  assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp, comparing a bypass and a non-bypass
// instance against a behavioural model of the register file and its clear sequence.
module tb_regfile_mp;
  logic        clk;
  logic        rst_n;
  logic [11:0] ra;
  logic        we0, we1, clr_req;
  logic [3:0]  wa0, wa1;
  logic [15:0] wd0, wd1;

  regfile_mp_if #(.n(16), .r(4), .NR(3)) bus_b ();
  regfile_mp_if #(.n(16), .r(4), .NR(3)) bus_nb ();

  assign bus_b.ra  = ra;   assign bus_nb.ra  = ra;
  assign bus_b.we0 = we0;  assign bus_nb.we0 = we0;
  assign bus_b.we1 = we1;  assign bus_nb.we1 = we1;
  assign bus_b.wa0 = wa0;  assign bus_nb.wa0 = wa0;
  assign bus_b.wa1 = wa1;  assign bus_nb.wa1 = wa1;
  assign bus_b.wd0 = wd0;  assign bus_nb.wd0 = wd0;
  assign bus_b.wd1 = wd1;  assign bus_nb.wd1 = wd1;
  assign bus_b.clr_req = clr_req;
  assign bus_nb.clr_req = clr_req;

  regfile_mp #(.n(16), .r(4), .NR(3), .BYPASS(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  regfile_mp #(.n(16), .r(4), .NR(3), .BYPASS(0)) u_dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: array contents, clear progress as a count of registers already zeroed.
  logic [15:0] mdl [16];
  bit          m_busy;
  bit          m_done;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [3:0] a, input bit byp);
    if (a == 4'd0) return 16'h0;
    if (byp && !m_busy) begin
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
    end
    return mdl[a];
  endfunction

  task automatic check_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_rd_byp"}, 32'(bus_b.rd[k*16 +: 16]), 32'(exp_rd(ra[k*4 +: 4], 1'b1)));
      check({tag, "_rd_nobyp"}, 32'(bus_nb.rd[k*16 +: 16]), 32'(exp_rd(ra[k*4 +: 4], 1'b0)));
    end
    check({tag, "_busy"}, 32'(bus_b.busy), 32'(m_busy));
    check({tag, "_busy_nb"}, 32'(bus_nb.busy), 32'(m_busy));
    check({tag, "_done"}, 32'(bus_b.clr_done), 32'(m_done));
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      m_done = 1'b0;
      if (we0 && wa0 != 4'd0) mdl[wa0] = wd0;
      if (we1 && wa1 != 4'd0) mdl[wa1] = wd1;
      if (clr_req) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      m_cnt++;
      mdl[m_cnt] = 16'h0;
      if (m_cnt == 15) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  // Called at a falling edge; drives, checks before the rising edge, then advances.
  task automatic cyc(input string tag, input logic w0, input logic [3:0] a0,
                     input logic [15:0] d0, input logic w1, input logic [3:0] a1,
                     input logic [15:0] d1, input logic c, input logic [11:0] ras);
    we0 = w0; wa0 = a0; wd0 = d0;
    we1 = w1; wa1 = a1; wd1 = d1;
    clr_req = c; ra = ras;
    #1;
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_read(input string tag, input logic [11:0] ras);
    cyc(tag, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, ras);
  endtask

  task automatic read_all(input string tag);
    for (int g = 0; g < 6; g++) begin
      idle_read(tag, {4'((g*3+2) % 16), 4'((g*3+1) % 16), 4'((g*3) % 16)});
    end
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
    ra = 12'($urandom);
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
    m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    #1;
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    ra = '0; we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    clr_req = 1'b0;
    @(negedge clk);
    apply_reset("reset");

    // Register 0 ignores writes.
    cyc("w_zero", 1'b1, 4'd0, 16'hBEEF, 1'b0, 4'd0, 16'h0, 1'b0, 12'h000);
    idle_read("rd_zero", 12'h000);

    // Dual write, then collision on one address.
    cyc("dual", 1'b1, 4'd3, 16'h1111, 1'b1, 4'd5, 16'h2222, 1'b0, 12'h053);
    idle_read("dual_rd", 12'h053);
    cyc("coll", 1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 16'h5555, 1'b0, 12'h777);
    idle_read("coll_rd", 12'h777);

    // Bypass on read port 2.
    cyc("bypass", 1'b1, 4'd9, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b0, 12'h953);
    idle_read("bypass_rd", 12'h953);

    // Fill, clear with a second request mid-clear and masked writes.
    for (int i = 1; i < 16; i++) begin
      cyc("fill", 1'b1, 4'(i), 16'(16'hA000 + i * 16'h0111), 1'b0, 4'd0, 16'h0, 1'b0,
          {4'(i), 4'(i), 4'(i)});
    end
    read_all("fill_rd");
    cyc("clr_start", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 12'hF21);
    for (int i = 0; i < 40 && m_busy; i++) begin
      cyc("clr_run", 1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd14, 16'hEEEE, (i == 5), 12'hEF1);
    end
    check("clr_finished", 32'(m_done), 32'(1));
    read_all("clr_rd");
    // Second clear; a write in the done cycle must land.
    cyc("clr2_start", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 12'h0F0);
    for (int i = 0; i < 40 && m_busy; i++) begin
      cyc("clr2_run", 1'b1, 4'd15, 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b0, 12'h0FF);
    end
    cyc("done_write", 1'b1, 4'd15, 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b0, 12'h0FF);
    idle_read("done_write_rd", 12'h0FF);

    // Reset in the middle of a clear.
    for (int i = 1; i < 16; i++) begin
      cyc("refill", 1'b1, 4'(i), 16'($urandom | 1), 1'b0, 4'd0, 16'h0, 1'b0, 12'(i));
    end
    cyc("clr3_start", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 12'h321);
    for (int i = 0; i < 6; i++) idle_read("clr3_run", 12'h987);
    apply_reset("reset_mid");
    read_all("post_reset_rd");
    cyc("clr4_start", 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 12'h321);
    for (int i = 0; i < 40 && m_busy; i++) idle_read("clr4_run", 12'hCBA);
    check("clr4_finished", 32'(m_done), 32'(1));
    idle_read("clr4_done", 12'hFED);

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      logic [3:0]  a0, a1;
      logic [11:0] ras;
      a0  = 4'($urandom);
      a1  = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom);
      ras = 12'($urandom);
      if ($urandom_range(0, 1) == 1) ras[3:0] = a0;
      if ($urandom_range(0, 1) == 1) ras[11:8] = a1;
      cyc("rand", 1'($urandom), a0, 16'($urandom), 1'($urandom), a1, 16'($urandom),
          ($urandom_range(0, 24) == 0), ras);
    end
    read_all("final_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
